// File: rtl/sensor_sched.sv
// -----------------------------------------------------------------------------
// sensor_sched
//   Periodic measurement scheduler. While enabled, it counts down a period
//   timer, requests a measurement from the SPI measurement FSM, compares the
//   returned value against the last stored value and, if the absolute change
//   exceeds the threshold, stores it and pulses an interrupt to the CPU.
//
// Ports
//   Clk_i                 clock, rising edge
//   Reset_n_i             asynchronous active-low reset
//   Enable_i              1 = periodic scheduling active
//   CpuIntr_o             one-cycle pulse: new significant value stored
//   SensorValue_o         last stored value {Byte1,Byte0}
//   MeasureFSM_Start_o    start request to the measurement FSM
//   MeasureFSM_Done_i     measurement FSM idle/done
//   MeasureFSM_Byte0_i    measurement result LSB
//   MeasureFSM_Byte1_i    measurement result MSB
//   ParamCounterPreset_i  period preset in cycles (period = preset + 1)
//   ParamThreshold_i      unsigned change threshold (strictly-greater test)
//   Error_o               transfer timeout flag (SENSOR_SCHED_TIMEOUT_EN only)
//
// Configuration
//   SENSOR_SCHED_TIMEOUT_EN  when defined, the timer also guards stXfer; a
//                            transfer that does not finish within preset+1
//                            cycles enters stError and raises Error_o.
// -----------------------------------------------------------------------------
module sensor_sched #(
    parameter int DataWidth = 8
) (
    input  logic                   Clk_i,
    input  logic                   Reset_n_i,
    input  logic                   Enable_i,
    output logic                   CpuIntr_o,
    output logic [2*DataWidth-1:0] SensorValue_o,
    output logic                   MeasureFSM_Start_o,
    input  logic                   MeasureFSM_Done_i,
    input  logic [DataWidth-1:0]   MeasureFSM_Byte0_i,
    input  logic [DataWidth-1:0]   MeasureFSM_Byte1_i,
    input  logic [31:0]            ParamCounterPreset_i,
    input  logic [2*DataWidth-1:0] ParamThreshold_i
`ifdef SENSOR_SCHED_TIMEOUT_EN
    ,
    output logic                   Error_o
`endif
);

    localparam int ValueWidth = 2 * DataWidth;

    typedef enum logic [2:0] {
        stDisabled,
        stIdle,
        stXfer,
        stNotify
`ifdef SENSOR_SCHED_TIMEOUT_EN
        ,
        stError
`endif
    } state_t;

    state_t                state;
    logic [31:0]           timer;
    logic                  timer_zero;
    logic [ValueWidth-1:0] new_value;
    logic [ValueWidth:0]   abs_diff;
    logic                  above_threshold;

    assign timer_zero = (timer == '0);
    assign new_value  = {MeasureFSM_Byte1_i, MeasureFSM_Byte0_i};

    // Absolute difference with one extra bit so the subtraction never wraps.
    always_comb begin
        abs_diff = '0;
        if (new_value >= SensorValue_o) begin
            abs_diff = {1'b0, new_value} - {1'b0, SensorValue_o};
        end else begin
            abs_diff = {1'b0, SensorValue_o} - {1'b0, new_value};
        end
    end

    assign above_threshold = (abs_diff > {1'b0, ParamThreshold_i});

    // Start is decoded from registered state so it is high exactly in the
    // stIdle cycle that moves to stXfer; Enable_i=0 has precedence and
    // suppresses it in that same cycle.
    assign MeasureFSM_Start_o = (state == stIdle) && Enable_i && timer_zero;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state         <= stDisabled;
            timer         <= '0;
            SensorValue_o <= '0;
            CpuIntr_o     <= 1'b0;
`ifdef SENSOR_SCHED_TIMEOUT_EN
            Error_o       <= 1'b0;
`endif
        end else begin
            CpuIntr_o <= 1'b0;
            case (state)
                stDisabled: begin
                    // Keeps the timer preloaded so stIdle entry starts a full period.
                    timer <= ParamCounterPreset_i;
                    if (Enable_i) begin
                        state <= stIdle;
                    end
                end

                stIdle: begin
                    if (!Enable_i) begin
                        state <= stDisabled;
                    end else if (timer_zero) begin
                        state <= stXfer;
`ifdef SENSOR_SCHED_TIMEOUT_EN
                        timer <= ParamCounterPreset_i;
`endif
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end

                stXfer: begin
                    if (MeasureFSM_Done_i) begin
                        timer <= ParamCounterPreset_i;
                        if (above_threshold) begin
                            SensorValue_o <= new_value;
                            CpuIntr_o     <= 1'b1;
                            state         <= stNotify;
                        end else begin
                            state <= stIdle;
                        end
                    end
`ifdef SENSOR_SCHED_TIMEOUT_EN
                    else if (timer_zero) begin
                        state   <= stError;
                        Error_o <= 1'b1;
                    end else begin
                        timer <= timer - 32'd1;
                    end
`endif
                end

                stNotify: begin
                    state <= stIdle;
                    timer <= ParamCounterPreset_i;
                end

`ifdef SENSOR_SCHED_TIMEOUT_EN
                stError: begin
                    if (!Enable_i) begin
                        state   <= stDisabled;
                        Error_o <= 1'b0;
                    end
                end
`endif

                default: begin
                    state <= stDisabled;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_sched.sv
// -----------------------------------------------------------------------------
// tb_sensor_sched
//   Directed bench for sensor_sched with a simple measurement-FSM model.
//   Expected compare outcomes are pushed to a queue when a result is driven
//   and popped when the scheduler has reacted to it.
//   Define SENSOR_SCHED_TIMEOUT_EN for both files to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_sensor_sched;

    localparam int DW = 8;
`ifdef SENSOR_SCHED_TIMEOUT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 20;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          intr;
    logic [2*DW-1:0] sv;
    logic          start;
    logic          done;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic [31:0]   preset;
    logic [2*DW-1:0] thr;
`ifdef SENSOR_SCHED_TIMEOUT_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    sensor_sched #(.DataWidth(DW)) dut (
        .Clk_i                (clk),
        .Reset_n_i            (rst_n),
        .Enable_i             (en),
        .CpuIntr_o            (intr),
        .SensorValue_o        (sv),
        .MeasureFSM_Start_o   (start),
        .MeasureFSM_Done_i    (done),
        .MeasureFSM_Byte0_i   (b0),
        .MeasureFSM_Byte1_i   (b1),
        .ParamCounterPreset_i (preset),
        .ParamThreshold_i     (thr)
`ifdef SENSOR_SCHED_TIMEOUT_EN
        ,
        .Error_o              (err)
`endif
    );

    typedef struct {
        bit          intr;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_val = 0;
    logic [31:0] run_preset = 32'd9;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a Start pulse; exp_wait>0 also checks the number of
    // falling edges from the call until Start is seen.
    task automatic wait_start(input int exp_wait, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start && n < 200);
        chk({tag, "_start"}, {31'd0, start}, 32'd1);
        if (exp_wait > 0) chk({tag, "_wait"}, n, exp_wait);
    endtask

    // One scheduled measurement served by the FSM model.
    task automatic xfer(input logic [15:0] val, input int lat, input int exp_wait,
                        input bit drop_en, input bit keep_notify, input string tag);
        exp_t e;
        int   d;
        wait_start(exp_wait, tag);
        done   = 1'b0;
        preset = run_preset;
        @(negedge clk);
        chk({tag, "_start_width"}, {31'd0, start}, 32'd0);
        if (drop_en) en = 1'b0;
        repeat (lat - 1) @(negedge clk);
        d = (int'(val) > model_val) ? int'(val) - model_val : model_val - int'(val);
        e.intr = (d > int'(thr));
        if (e.intr) model_val = int'(val);
        e.val = model_val[15:0];
        sb.push_back(e);
        {b1, b0} = val;
        done = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, "_intr"}, {31'd0, intr}, {31'd0, e.intr});
        chk({tag, "_value"}, {16'd0, sv}, {16'd0, e.val});
        if (e.intr && !keep_notify) begin
            @(negedge clk);
            chk({tag, "_intr_fall"}, {31'd0, intr}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n  = 1'b0;
        en     = 1'b1;
        done   = 1'b1;
        b0     = '0;
        b1     = '0;
        preset = 32'd9;
        thr    = 16'd16;
        repeat (3) @(negedge clk);
        chk("rst_intr", {31'd0, intr}, 32'd0);
        chk("rst_value", {16'd0, sv}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
`ifdef SENSOR_SCHED_TIMEOUT_EN
        chk("rst_err", {31'd0, err}, 32'd0);
`endif
        rst_n = 1'b1;

        // Period P+1 and first store
        xfer(16'h0100, LAT, 10, 1'b0, 1'b0, "first");
        // Threshold boundary: D=16 holds, D=17 stores
        xfer(16'h0110, LAT, 9, 1'b0, 1'b0, "d16");
        xfer(16'h0111, LAT, 9, 1'b0, 1'b0, "d17");
        // Large change without wrap
        xfer(16'hFFF0, LAT, 9, 1'b0, 1'b0, "high");
        thr = 16'd100;
        xfer(16'h0005, LAT, 9, 1'b0, 1'b0, "nowrap");
        // Threshold 0: equal holds, any difference stores
        thr = 16'd0;
        xfer(16'h0005, LAT, 9, 1'b0, 1'b0, "t0_equal");
        xfer(16'h0006, LAT, 9, 1'b0, 1'b0, "t0_diff");

        // Enable dropped mid-transfer: completes, stores, then stays disabled
        xfer(16'h1234, LAT, 9, 1'b1, 1'b0, "drop_en");
        s = 0;
        repeat (40) begin
            @(negedge clk);
            if (start) s++;
        end
        chk("disabled_no_start", s, 0);

        // Preset 0: Start on the first stIdle cycle
        preset = 32'd0;
        en     = 1'b1;
        xfer(16'h1234, LAT, 1, 1'b0, 1'b0, "p0");

        // Asynchronous reset while in stNotify
        xfer(16'h00FF, LAT, 9, 1'b0, 1'b1, "notify");
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_intr", {31'd0, intr}, 32'd0);
        chk("async_rst_value", {16'd0, sv}, 32'd0);
        chk("async_rst_start", {31'd0, start}, 32'd0);
        model_val = 0;
        preset    = 32'd3;
        @(negedge clk);
        chk("in_rst_start", {31'd0, start}, 32'd0);
        rst_n = 1'b1;
        xfer(16'h0000, LAT, 4, 1'b0, 1'b0, "post_rst");

`ifdef SENSOR_SCHED_TIMEOUT_EN
        // Transfer timeout with Done held low
        run_preset = 32'd5;
        preset     = 32'd5;
        wait_start(-1, "to");
        done = 1'b0;
        s = 0;
        do begin
            @(negedge clk);
            s++;
        end while (!err && s < 50);
        chk("to_err_cycles", s, 7);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_start", {31'd0, start}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk("to_err_clear", {31'd0, err}, 32'd0);
        en   = 1'b1;
        done = 1'b1;
        xfer(16'h4321, 2, 6, 1'b0, 1'b0, "resume");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
